// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and constants for the prefetch-FIFO read-port arbiter.
package fifo_read_arbiter_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    localparam int BYTE_CNT_W = 4;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = 4'd15;

    // Tenure byte counter step that sticks at BYTE_CNT_MAX.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] value);
        return (value == BYTE_CNT_MAX) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Handshake bundle between the decode sub-units, the arbiter and the FIFO flags.
interface fifo_read_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import fifo_read_arbiter_pkg::*;

    logic [NUM_REQ-1:0]    req;
    // Owner's end-of-tenure pulse; "release" itself is a reserved word.
    logic [NUM_REQ-1:0]    tenure_release;
    logic                  flush;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [NUM_REQ-1:0]    req_rd_en;
    logic [NUM_REQ-1:0]    req_fifo_empty;
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [BYTE_CNT_W-1:0] bytes_consumed;
    logic                  protocol_error;

    modport slave (
        input  req, tenure_release, flush, req_rd_en, fifo_empty,
        output grant, busy, req_fifo_empty, fifo_rd_en, bytes_consumed, protocol_error
    );

    modport master (
        output req, tenure_release, flush, req_rd_en, fifo_empty,
        input  grant, busy, req_fifo_empty, fifo_rd_en, bytes_consumed, protocol_error
    );

endinterface

// File: rtl/fifo_read_arbiter_rr_picker.sv
// Combinational round-robin picker: search starts just after last_owner and
// wraps, optionally skipping one excluded index.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    input  logic               exclude_en,
    input  logic [IDX_W-1:0]   exclude_idx,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    int unsigned      base;
    logic [IDX_W-1:0] idx;

    // First eligible requester in rotating order wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        base  = 32'(last_owner);
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((base + k) % NUM_REQ);
            if (!valid && req[idx] && !(exclude_en && (idx == exclude_idx))) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin owner of the prefetch-FIFO read port with tenure byte count
// and sticky protocol-violation flag.
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    fifo_read_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    arb_state_t            state;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IDX_W-1:0]      last_owner;
    logic [BYTE_CNT_W-1:0] count_q;
    logic                  error_q;

    logic [NUM_REQ-1:0]    pick;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    logic                  owner_release;
    logic                  owner_rd;
    logic                  owner_still_req;
    logic                  fifo_rd;
    logic                  violation;

    // While owned, the owner is excluded so another requester gets the next
    // turn; the owner is re-granted only when nobody else is waiting.
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (bus.req),
        .last_owner  (last_owner),
        .exclude_en  (state == OWNED),
        .exclude_idx (last_owner),
        .pick        (pick),
        .valid       (pick_valid)
    );

    // One-hot pick to index for the last_owner register.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Owner-qualified strobes and violation detection.
    always_comb begin
        owner_release   = |(bus.tenure_release & grant_q);
        owner_rd        = |(bus.req_rd_en & grant_q);
        owner_still_req = |(bus.req & grant_q);
        fifo_rd         = owner_rd & ~bus.fifo_empty;
        violation       = (|(bus.req_rd_en & ~grant_q))
                        | (|(bus.tenure_release & ~grant_q))
                        | (owner_rd & bus.fifo_empty);
    end

    // Tenure FSM with registered grant, byte counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_owner <= LAST_RESET;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            if (violation) begin
                error_q <= 1'b1;
            end
            if (bus.flush) begin
                state   <= IDLE;
                grant_q <= '0;
                count_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_valid) begin
                            state      <= OWNED;
                            grant_q    <= pick;
                            last_owner <= pick_idx;
                            count_q    <= '0;
                        end
                    end
                    OWNED: begin
                        if (owner_release) begin
                            if (pick_valid) begin
                                grant_q    <= pick;
                                last_owner <= pick_idx;
                                count_q    <= '0;
                            end else if (owner_still_req) begin
                                count_q <= '0;
                            end else begin
                                state   <= IDLE;
                                grant_q <= '0;
                                if (fifo_rd) begin
                                    count_q <= sat_inc(count_q);
                                end
                            end
                        end else if (fifo_rd) begin
                            count_q <= sat_inc(count_q);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.grant          = grant_q;
    assign bus.busy           = |grant_q;
    assign bus.req_fifo_empty = {NUM_REQ{bus.fifo_empty}} | ~grant_q;
    assign bus.fifo_rd_en     = fifo_rd;
    assign bus.bytes_consumed = count_q;
    assign bus.protocol_error = error_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed scenarios plus a randomized run against a tenure-level reference model.
module tb_fifo_read_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    fifo_read_arbiter_if #(.NUM_REQ(N)) bus ();

    fifo_read_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req            = '0;
        bus.tenure_release = '0;
        bus.flush          = 1'b0;
        bus.req_rd_en      = '0;
        bus.fifo_empty     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", bus.fifo_rd_en); end
        total++; if (bus.bytes_consumed !== 4'd0) begin bad++; $display("FAIL reset_bytes got=%0d exp=0", bus.bytes_consumed); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.protocol_error); end
        total++; if (bus.req_fifo_empty !== 3'b111) begin bad++; $display("FAIL reset_rfe got=%b exp=111", bus.req_fifo_empty); end
        reset = 1'b0;
    endtask

    task automatic test_grant_latency();
        bus.req = 3'b011;
        @(negedge clk);
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL lat_same_cycle got=%b exp=000", bus.grant); end
        step();
        total++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL lat_grant got=%b exp=001", bus.grant); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b exp=1", bus.busy); end
        total++; if (bus.req_fifo_empty !== 3'b110) begin bad++; $display("FAIL lat_rfe got=%b exp=110", bus.req_fifo_empty); end
    endtask

    task automatic test_handover();
        int rd_cycles = 0;
        bus.req_rd_en = 3'b001;
        repeat (3) begin
            @(negedge clk);
            if (bus.fifo_rd_en === 1'b1) rd_cycles++;
            step();
        end
        bus.req_rd_en = 3'b000;
        bus.req = 3'b110;
        bus.tenure_release = 3'b001;
        @(negedge clk);
        if (bus.fifo_rd_en === 1'b1) rd_cycles++;
        total++; if (rd_cycles != 3) begin bad++; $display("FAIL ho_rd_cycles got=%0d exp=3", rd_cycles); end
        total++; if (bus.bytes_consumed !== 4'd3) begin bad++; $display("FAIL ho_bytes got=%0d exp=3", bus.bytes_consumed); end
        step();
        bus.tenure_release = 3'b000;
        total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL ho_grant got=%b exp=010", bus.grant); end
        total++; if (bus.bytes_consumed !== 4'd0) begin bad++; $display("FAIL ho_bytes_clr got=%0d exp=0", bus.bytes_consumed); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL ho_err got=%b exp=0", bus.protocol_error); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [4];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        do_reset();
        bus.req = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.grant !== seq[k]) begin bad++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, bus.grant, seq[k]); end
            bus.tenure_release = seq[k];
            step();
        end
        bus.tenure_release = '0;
        total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL rr_wrap got=%b exp=010", bus.grant); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL rr_err got=%b exp=0", bus.protocol_error); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.req = 3'b001;
        step();
        bus.req_rd_en = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++; if (bus.bytes_consumed !== 4'((k > 15) ? 15 : k)) begin
                bad++; $display("FAIL sat_bytes k=%0d got=%0d exp=%0d", k, bus.bytes_consumed, (k > 15) ? 15 : k);
            end
        end
        bus.req_rd_en = 3'b000;
        step();
        total++; if (bus.bytes_consumed !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", bus.bytes_consumed); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL sat_err got=%b exp=0", bus.protocol_error); end
        bus.fifo_empty = 1'b1;
        bus.req_rd_en = 3'b001;
        @(negedge clk);
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL empty_rd got=%b exp=0", bus.fifo_rd_en); end
        total++; if (bus.req_fifo_empty !== 3'b111) begin bad++; $display("FAIL empty_rfe got=%b exp=111", bus.req_fifo_empty); end
        step();
        bus.req_rd_en = 3'b000;
        bus.fifo_empty = 1'b0;
        total++; if (bus.protocol_error !== 1'b1) begin bad++; $display("FAIL empty_err got=%b exp=1", bus.protocol_error); end
        total++; if (bus.bytes_consumed !== 4'd15) begin bad++; $display("FAIL empty_bytes got=%0d exp=15", bus.bytes_consumed); end
    endtask

    task automatic test_nonowner_read();
        do_reset();
        bus.req = 3'b001;
        step();
        bus.req_rd_en = 3'b100;
        @(negedge clk);
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL nonown_rd got=%b exp=0", bus.fifo_rd_en); end
        step();
        bus.req_rd_en = 3'b000;
        total++; if (bus.protocol_error !== 1'b1) begin bad++; $display("FAIL nonown_err got=%b exp=1", bus.protocol_error); end
        repeat (3) step();
        total++; if (bus.protocol_error !== 1'b1) begin bad++; $display("FAIL nonown_sticky got=%b exp=1", bus.protocol_error); end
        do_reset();
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL nonown_clr got=%b exp=0", bus.protocol_error); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.req = 3'b001;
        step();
        bus.req_rd_en = 3'b001;
        step();
        step();
        bus.req = 3'b111;
        bus.flush = 1'b1;
        bus.tenure_release = 3'b001;
        @(negedge clk);
        total++; if (bus.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL flush_rd got=%b exp=1", bus.fifo_rd_en); end
        step();
        bus.flush = 1'b0;
        bus.tenure_release = 3'b000;
        bus.req_rd_en = 3'b000;
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL flush_grant got=%b exp=000", bus.grant); end
        total++; if (bus.bytes_consumed !== 4'd0) begin bad++; $display("FAIL flush_bytes got=%0d exp=0", bus.bytes_consumed); end
        step();
        total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL flush_regrant got=%b exp=010", bus.grant); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", bus.protocol_error); end
    endtask

    task automatic test_reset_mid_tenure();
        bus.req_rd_en = 3'b110;
        reset = 1'b1;
        step();
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b exp=000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_rd got=%b exp=0", bus.fifo_rd_en); end
        total++; if (bus.bytes_consumed !== 4'd0) begin bad++; $display("FAIL midrst_bytes got=%0d exp=0", bus.bytes_consumed); end
        total++; if (bus.protocol_error !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", bus.protocol_error); end
        total++; if (bus.req_fifo_empty !== 3'b111) begin bad++; $display("FAIL midrst_rfe got=%b exp=111", bus.req_fifo_empty); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_random();
        int owner, last, cnt, p;
        int n_owner, n_last, n_cnt;
        bit err, n_err, exp_rd;
        logic [N-1:0] exp_grant, exp_rfe;
        do_reset();
        owner = -1; last = N - 1; cnt = 0; err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.req        = 3'($urandom);
            bus.fifo_empty = ($urandom_range(0, 3) == 0);
            bus.flush      = ($urandom_range(0, 29) == 0);
            reset          = ($urandom_range(0, 199) == 0);
            bus.tenure_release = (owner >= 0 && $urandom_range(0, 3) == 0) ? 3'(1 << owner) : 3'b000;
            if ($urandom_range(0, 49) == 0) bus.tenure_release = 3'($urandom);
            bus.req_rd_en = (owner >= 0 && $urandom_range(0, 1) == 1) ? 3'(1 << owner) : 3'b000;
            if ($urandom_range(0, 59) == 0) bus.req_rd_en = 3'($urandom);
            @(negedge clk);
            exp_grant = (owner >= 0) ? 3'(1 << owner) : 3'b000;
            exp_rd    = (owner >= 0) && bus.req_rd_en[owner] && !bus.fifo_empty;
            exp_rfe   = bus.fifo_empty ? 3'b111 : ~exp_grant;
            total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, bus.grant, exp_grant); end
            total++; if (bus.busy !== (owner >= 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, owner >= 0); end
            total++; if (bus.fifo_rd_en !== exp_rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%b exp=%b", cyc, bus.fifo_rd_en, exp_rd); end
            total++; if (bus.req_fifo_empty !== exp_rfe) begin bad++; $display("FAIL rnd_rfe cyc=%0d got=%b exp=%b", cyc, bus.req_fifo_empty, exp_rfe); end
            total++; if (bus.bytes_consumed !== 4'(cnt)) begin bad++; $display("FAIL rnd_bytes cyc=%0d got=%0d exp=%0d", cyc, bus.bytes_consumed, cnt); end
            total++; if (bus.protocol_error !== err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.protocol_error, err); end
            n_owner = owner; n_last = last; n_cnt = cnt; n_err = err;
            if (reset) begin
                n_owner = -1; n_last = N - 1; n_cnt = 0; n_err = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (i != owner && (bus.req_rd_en[i] || bus.tenure_release[i])) n_err = 1'b1;
                end
                if (owner >= 0 && bus.req_rd_en[owner] && bus.fifo_empty) n_err = 1'b1;
                if (bus.flush) begin
                    n_owner = -1; n_cnt = 0;
                end else if (owner < 0) begin
                    p = rr_pick(bus.req, last);
                    if (p >= 0) begin n_owner = p; n_last = p; n_cnt = 0; end
                end else begin
                    n_cnt = (cnt + int'(exp_rd) > 15) ? 15 : cnt + int'(exp_rd);
                    if (bus.tenure_release[owner]) begin
                        p = rr_pick(bus.req, last);
                        if (p >= 0) begin n_owner = p; n_last = p; n_cnt = 0; end
                        else n_owner = -1;
                    end
                end
            end
            step();
            owner = n_owner; last = n_last; cnt = n_cnt; err = n_err;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_grant_latency();
        test_handover();
        test_round_robin();
        test_saturation();
        test_nonowner_read();
        test_flush();
        test_reset_mid_tenure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Round-robin arbiter that shares the single prefetch-FIFO read port between byte consumers (opcode fetch, ModRM decode, immediate reader). A requester gains exclusive tenure of the port until it releases it. While a requester is granted, only its read strobe reaches the FIFO, and every other requester sees an empty FIFO. The arbiter also counts the bytes consumed in the current tenure and flags protocol violations. It sits between the instruction FIFO and the decode sub-units, in place of a plain OR of read enables.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..8; index 0 is the highest priority after reset

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level; requester i wants tenure of the read port
- release  in  NUM_REQ  one-cycle pulse; owner ends its tenure (tie to the sub-unit's complete)
- flush  in  1  pulse; abort the current tenure (branch/interrupt)
- grant  out  NUM_REQ  one-hot or zero; registered ownership
- busy  out  1  |grant
- req_rd_en  in  NUM_REQ  per-requester read strobe
- req_fifo_empty  out  NUM_REQ  fifo_empty | ~grant[i]
- fifo_rd_en  out  1  req_rd_en[owner] & grant[owner] & ~fifo_empty
- fifo_empty  in  1  FIFO empty flag
- bytes_consumed  out  4  bytes read in the current/last tenure, saturating at 15
- protocol_error  out  1  sticky violation flag

## Operation
- States (arb_state_t): IDLE, OWNED. Reset enters IDLE.
- IDLE: if any req is set, the round-robin pick starts at index last_owner+1 modulo NUM_REQ.
  - grant[pick] is registered.
  - bytes_consumed clears to 0.
  - State goes to OWNED.
- OWNED, owner asserts release: tenure ends.
  - If any req other than the owner's is set, the next pick is granted on the same edge (zero idle cycles); the search starts after the owner.
  - If only the owner still requests, it is re-granted.
  - If nothing requests, the block goes to IDLE.
  - last_owner updates on every grant.
- flush, in any state: grant clears and the block goes to IDLE on the next edge. No new grant is issued on that edge. bytes_consumed clears. flush overrides release and req.
- A read strobe in the same cycle as release or flush is honoured: fifo_rd_en is combinational and the byte is counted.
- bytes_consumed increments on each cycle with fifo_rd_en=1 and saturates at 15. It holds its value after release until the next grant, so a sequencer can sample instruction length.
- protocol_error is set, and stays set until reset, on any of:
  - req_rd_en[i] with grant[i]=0
  - release[i] with grant[i]=0
  - req_rd_en[owner] while fifo_empty=1 (the read is suppressed)
- Read data is not muxed; all requesters sample fifo_rd_data directly.

## Timing
- Reset values:
  - grant=0, busy=0, fifo_rd_en=0, bytes_consumed=0, protocol_error=0
  - last_owner=NUM_REQ-1, so index 0 wins first
  - req_fifo_empty=all ones
- Grant latency: req rises in cycle N while IDLE → grant high in N+1. Earliest read is N+1.
- Handover: release in cycle N → new grant in N+1.
- req_fifo_empty and fifo_rd_en are combinational from the registered grant; there are no same-cycle paths from req to grant.
- Reset asserted mid-tenure: all outputs reach their reset values on that edge, and any pending read strobe is dropped.
- req withdrawn by the owner without release: tenure is kept. Ownership ends only on release or flush.

## Structure
- Shared package holds arb_state_t (IDLE, OWNED) and the BYTE_CNT_MAX=15 constant.
- Sub-module rr_picker (combinational): inputs req, last_owner, excluded index; outputs one-hot pick and valid.
- Remainder is a single module: state register, grant register, counter, and error flag. Target 150–250 lines.

## Test plan
- Reset, then req=3'b011 → grant=3'b001 one cycle later, busy=1. Requester 1 sees req_fifo_empty[1]=1.
- Owner 0 reads 3 bytes with the FIFO non-empty, then pulses release while req=3'b110 → fifo_rd_en high for exactly 3 cycles. bytes_consumed=3. Next cycle grant=3'b010.
- Round-robin: all requesters hold req, each releases after 1 cycle → grant sequence 001, 010, 100, 001 with no idle cycles.
- Owner strobes 20 reads with the FIFO always full → bytes_consumed=15 and holds. Owner strobes while fifo_empty=1 → fifo_rd_en=0 and protocol_error=1.
- Non-owner 2 asserts req_rd_en while grant=3'b001 → fifo_rd_en=0 and protocol_error=1 until reset.
- flush and release together mid-tenure, req=3'b111 → grant=0 next cycle and bytes_consumed=0. Grant then goes to 3'b010 one cycle later. Reset mid-tenure → every output at its reset value next cycle.
